// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: enqueue side, dequeue side, flush and occupancy.
// slave = the queue itself, master = whoever drives fetch/decode around it.
interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_instr;
    logic             enq_pred_taken;
    logic             deq_valid;
    logic             deq_ready;
    logic [31:0]      deq_pc;
    logic [31:0]      deq_instr;
    logic             deq_pred_taken;
    logic [PTR_W:0]   count;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // enq_ready never depends combinationally on deq_ready.
    modport slave (
        input  flush, enq_valid, enq_pc, enq_instr, enq_pred_taken, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_taken, count
    );

    modport master (
        output flush, enq_valid, enq_pc, enq_instr, enq_pred_taken, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_pred_taken, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue between fetch and decode: first-word fall-through, one-cycle flush.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards enq_* straight to deq_* in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [31:0]  NOP = 32'h0000_0013;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] r_head;
    logic [PTR_W:0] r_tail;
    logic [64:0]    r_mem [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_enq_ready;
    logic        w_show;
    logic        w_enq_fire;
    logic        w_deq_fire;
    logic [64:0] w_enq_entry;
    logic [64:0] w_head_entry;
    logic [64:0] w_src;

    // Entry layout: {pred_taken, pc, instr}
    assign w_enq_entry  = {q.enq_pred_taken, q.enq_pc, q.enq_instr};
    assign w_head_entry = r_mem[r_head[PTR_W-1:0]];

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]) && (r_head[PTR_W] != r_tail[PTR_W]);

    assign w_enq_ready = !w_full && !q.flush && !rst;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = w_empty && q.enq_valid && !q.flush && !rst;
    assign w_show     = (!w_empty || w_bypass) && !q.flush;
    assign w_src      = w_bypass ? w_enq_entry : w_head_entry;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_enq_fire = q.enq_valid && w_enq_ready && !(w_bypass && q.deq_ready);
`else
    assign w_show     = !w_empty && !q.flush;
    assign w_src      = w_head_entry;
    assign w_enq_fire = q.enq_valid && w_enq_ready;
`endif

    assign w_deq_fire = w_show && q.deq_ready && !w_empty;

    assign q.enq_ready      = w_enq_ready;
    assign q.deq_valid      = w_show;
    assign q.deq_pred_taken = w_show ? w_src[64]    : 1'b0;
    assign q.deq_pc         = w_show ? w_src[63:32] : 32'h0;
    assign q.deq_instr      = w_show ? w_src[31:0]  : NOP;
    assign q.count          = r_tail - r_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (q.flush) begin
            r_head <= r_tail;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + PTR_ONE;
            if (w_deq_fire) r_head <= r_head + PTR_ONE;
        end
    end

    // Storage has no reset; stale slots are masked by the empty check.
    always_ff @(posedge clk) begin
        if (w_enq_fire) r_mem[r_tail[PTR_W-1:0]] <= w_enq_entry;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations plus a
// randomized phase, all compared each cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [64:0] mq [$];

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference view of the outputs from the queue contents and current inputs.
    function automatic void model_view(output bit er, output bit ev, output bit byp,
                                       output logic [64:0] data);
        er   = (mq.size() < DEPTH) && !bus.flush && !rst;
        byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp  = (mq.size() == 0) && bus.enq_valid && !bus.flush && !rst;
`endif
        ev   = ((mq.size() > 0) || byp) && !bus.flush;
        if (byp)
            data = {bus.enq_pred_taken, bus.enq_pc, bus.enq_instr};
        else if (mq.size() > 0)
            data = mq[0];
        else
            data = '0;
        if (!ev) data = {1'b0, 32'h0, NOP};
    endfunction

    // Model state update on the active edge.
    always @(posedge clk) begin
        bit er, ev, byp;
        logic [64:0] d;
        bit enq_f, deq_f;
        if (!rst) begin
            model_view(er, ev, byp, d);
            enq_f = bus.enq_valid && er && !(byp && bus.deq_ready);
            deq_f = ev && bus.deq_ready && (mq.size() > 0);
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (deq_f) void'(mq.pop_front());
                if (enq_f) mq.push_back({bus.enq_pred_taken, bus.enq_pc, bus.enq_instr});
            end
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        bit er, ev, byp;
        logic [64:0] d;
        model_view(er, ev, byp, d);
        chk("enq_ready", 64'(bus.enq_ready), 64'(er));
        chk("deq_valid", 64'(bus.deq_valid), 64'(ev));
        chk("deq_pc", 64'(bus.deq_pc), 64'(d[63:32]));
        chk("deq_instr", 64'(bus.deq_instr), 64'(d[31:0]));
        chk("deq_pred", 64'(bus.deq_pred_taken), 64'(d[64]));
        chk("count", 64'(bus.count), 64'(mq.size()));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.enq_valid      = 1'b0;
        bus.deq_ready      = 1'b0;
        bus.enq_pc         = '0;
        bus.enq_instr      = '0;
        bus.enq_pred_taken = 1'b0;
    endtask

    task automatic enq_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.enq_valid      = 1'b1;
            bus.enq_pc         = base + 32'(4 * i);
            bus.enq_instr      = $urandom;
            bus.enq_pred_taken = 1'($urandom_range(0, 1));
            step();
        end
        bus.enq_valid = 1'b0;
    endtask

    task automatic deq_n(input int n);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        bus.deq_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst = 1'b1;
        #2;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("rst_deq_instr", 64'(bus.deq_instr), 64'(NOP));
        chk("rst_deq_pc", 64'(bus.deq_pc), 64'd0);
        #10;
        rst = 1'b0;
        step();

        // Basic pass-through
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 32'h60;
        bus.enq_instr = 32'h0050_0093;
        step();
        bus.enq_valid = 1'b0;
        #1;
        chk("pt_valid", 64'(bus.deq_valid), 64'd1);
        chk("pt_pc", 64'(bus.deq_pc), 64'h60);
        chk("pt_instr", 64'(bus.deq_instr), 64'h0050_0093);
        chk("pt_count", 64'(bus.count), 64'd1);
        bus.deq_ready = 1'b1;
        step();
        bus.deq_ready = 1'b0;
        #1;
        chk("pt_empty_valid", 64'(bus.deq_valid), 64'd0);
        chk("pt_empty_instr", 64'(bus.deq_instr), 64'(NOP));

        // Fill to full, then reject a ninth entry
        enq_n(32'h100, 8);
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 32'h999;
        step();
        bus.enq_valid = 1'b0;
        chk("full_ninth_count", 64'(bus.count), 64'd8);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", 64'(bus.deq_pc), 64'(32'h100 + 32'(4 * i)));
            step();
        end
        bus.deq_ready = 1'b0;
        chk("drain_count", 64'(bus.count), 64'd0);

        // Wrap-around
        enq_n(32'h180, 5);
        deq_n(5);
        chk("wrap_count0", 64'(bus.count), 64'd0);
        enq_n(32'h200, 6);
        chk("wrap_count6", 64'(bus.count), 64'd6);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("wrap_order", 64'(bus.deq_pc), 64'(32'h200 + 32'(4 * i)));
            step();
        end
        bus.deq_ready = 1'b0;
        chk("wrap_count_end", 64'(bus.count), 64'd0);

        // Simultaneous enqueue/dequeue at count 3
        enq_n(32'h500, 3);
        bus.enq_valid = 1'b1;
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.enq_pc    = 32'h50C + 32'(4 * i);
            bus.enq_instr = $urandom;
            #1;
            chk("sim_count", 64'(bus.count), 64'd3);
            chk("sim_order", 64'(bus.deq_pc), 64'(32'h500 + 32'(4 * i)));
            step();
        end
        bus.enq_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("sim_tail", 64'(bus.deq_pc), 64'(32'h528 + 32'(4 * j)));
            step();
        end
        bus.deq_ready = 1'b0;

        // Flush with both handshakes requested
        enq_n(32'h280, 4);
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 32'h2FF;
        bus.deq_ready = 1'b1;
        #1;
        chk("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("flush_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("flush_instr", 64'(bus.deq_instr), 64'(NOP));
        step();
        idle();
        #1;
        chk("post_flush_count", 64'(bus.count), 64'd0);
        chk("post_flush_valid", 64'(bus.deq_valid), 64'd0);
        enq_n(32'h300, 1);
        chk("post_flush_pc", 64'(bus.deq_pc), 64'h300);
        chk("post_flush_v", 64'(bus.deq_valid), 64'd1);
        deq_n(1);

        // Asynchronous reset between edges
        enq_n(32'h380, 5);
        chk("pre_rst_count", 64'(bus.count), 64'd5);
        #2;
        rst = 1'b1;
        mq.delete();
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_deq_valid", 64'(bus.deq_valid), 64'd0);
        chk("arst_enq_ready", 64'(bus.enq_ready), 64'd0);
        rst = 1'b0;
        step();
        chk("arst_release_ready", 64'(bus.enq_ready), 64'd1);
        chk("arst_release_count", 64'(bus.count), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 32'h400;
        bus.deq_ready = 1'b1;
        #1;
        chk("byp_pc", 64'(bus.deq_pc), 64'h400);
        chk("byp_valid", 64'(bus.deq_valid), 64'd1);
        step();
        idle();
        #1;
        chk("byp_count", 64'(bus.count), 64'd0);
`endif

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 600; i++) begin
            bit fill_bias;
            fill_bias          = ((i / 50) % 2) == 0;
            bus.enq_valid      = fill_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bus.deq_ready      = fill_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.flush          = ($urandom_range(0, 29) == 0);
            bus.enq_pc         = $urandom;
            bus.enq_instr      = $urandom;
            bus.enq_pred_taken = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
